// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying a payload, a control vector and a squash flag.
// The producer side uses modport master, the consumer side modport slave.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  logic              kill;

  modport master (output valid, output data, output ctrl, output kill, input ready);
  modport slave  (input valid, input data, input ctrl, input kill, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional two-entry skid buffer, per-beat control
// squash, global flush and a saturating back-pressure cycle counter.
module pipe_stage_reg #(
  parameter int               DATA_W    = 16,
  parameter int               CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter bit               SKID      = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_stage_reg_if.slave       up,
  pipe_stage_reg_if.master      dn,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [CNT_W-1:0]  stall_q,   stall_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              drain_s;
  logic [CTRL_W-1:0] in_ctrl_s;

  // Handshake decode and squash of the incoming control vector
  always_comb begin
    in_ready_s = 1'b0;
    if (SKID) begin
      in_ready_s = ~s_valid_q;
    end else begin
      in_ready_s = ~m_valid_q | dn.ready;
    end
    accept_s = up.valid & in_ready_s;
    drain_s  = m_valid_q & dn.ready;
    if (up.kill) begin
      in_ctrl_s = up.ctrl & ~KILL_MASK;
    end else begin
      in_ctrl_s = up.ctrl;
    end
  end

  // Next-state selection for the main and skid entries; flush outranks all moves
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (drain_s && s_valid_q) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_q;
      m_ctrl_d  = s_ctrl_q;
      s_valid_d = 1'b0;
    end else if (accept_s && (!m_valid_q || drain_s)) begin
      m_valid_d = 1'b1;
      m_data_d  = up.data;
      m_ctrl_d  = in_ctrl_s;
    end else if (accept_s && SKID) begin
      // M is full and holding: park the beat in S so in_ready can stay registered
      s_valid_d = 1'b1;
      s_data_d  = up.data;
      s_ctrl_d  = in_ctrl_s;
    end else if (drain_s) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Saturating count of cycles where the head beat is blocked downstream
  always_comb begin
    stall_d = stall_q;
    if (m_valid_q && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_W{1'b0}};
      m_ctrl_q  <= {CTRL_W{1'b0}};
      s_valid_q <= 1'b0;
      s_data_q  <= {DATA_W{1'b0}};
      s_ctrl_q  <= {CTRL_W{1'b0}};
      stall_q   <= {CNT_W{1'b0}};
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
      stall_q   <= stall_d;
    end
  end

  assign up.ready  = in_ready_s;
  assign dn.valid  = m_valid_q;
  assign dn.data   = m_data_q;
  assign dn.ctrl   = m_ctrl_q;
  assign dn.kill   = 1'b0;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, non-skid and narrow-counter instances
// share clock and reset; each is exercised with hand-computed expectations.
module tb_pipe_stage_reg;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic        flush1, flush0, flush4;
  logic [1:0]  occ1, occ0, occ4;
  logic [15:0] stall1, stall0;
  logic [3:0]  stall4;

  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) up1 ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) dn1 ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) up0 ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) dn0 ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) up4 ();
  pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(16)) dn4 ();

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .KILL_MASK(16'h00F0), .SKID(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .up(up1.slave), .dn(dn1.master),
    .flush(flush1), .occupancy(occ1), .stall_cnt(stall1));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .SKID(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .up(up0.slave), .dn(dn0.master),
    .flush(flush0), .occupancy(occ0), .stall_cnt(stall0));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .SKID(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .up(up4.slave), .dn(dn4.master),
    .flush(flush4), .occupancy(occ4), .stall_cnt(stall4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    flush1 = 1'b0; flush0 = 1'b0; flush4 = 1'b0;
    up1.valid = 1'b0; up1.data = 16'h0000; up1.ctrl = 16'h0000; up1.kill = 1'b0; dn1.ready = 1'b0;
    up0.valid = 1'b0; up0.data = 16'h0000; up0.ctrl = 16'h0000; up0.kill = 1'b0; dn0.ready = 1'b0;
    up4.valid = 1'b0; up4.data = 16'h0000; up4.ctrl = 16'h0000; up4.kill = 1'b0; dn4.ready = 1'b0;
    #12;
    check_eq("rst_out_valid", {31'd0, dn1.valid}, 32'd0);
    check_eq("rst_in_ready1", {31'd0, up1.ready}, 32'd1);
    check_eq("rst_in_ready0", {31'd0, up0.ready}, 32'd1);
    check_eq("rst_occ", {30'd0, occ1}, 32'd0);
    check_eq("rst_data", {16'd0, dn1.data}, 32'd0);
    check_eq("rst_ctrl", {16'd0, dn1.ctrl}, 32'd0);
    check_eq("rst_stall", {16'd0, stall1}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Streaming with out_ready high
    dn1.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up1.valid = 1'b1;
      up1.data  = 16'(i);
      check_eq("stream_in_ready", {31'd0, up1.ready}, 32'd1);
      tick();
      check_eq("stream_valid", {31'd0, dn1.valid}, 32'd1);
      check_eq("stream_data", {16'd0, dn1.data}, i);
    end
    up1.valid = 1'b0;
    tick();
    check_eq("stream_idle", {31'd0, dn1.valid}, 32'd0);
    check_eq("stream_stall", {16'd0, stall1}, 32'd0);

    // Back-pressure into the skid entry
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 16'hAAAA;
    tick();
    check_eq("bp_head_a", {16'd0, dn1.data}, 32'hAAAA);
    check_eq("bp_ready_a", {31'd0, up1.ready}, 32'd1);
    up1.data = 16'hBBBB;
    tick();
    up1.valid = 1'b0;
    check_eq("bp_occ2", {30'd0, occ1}, 32'd2);
    check_eq("bp_ready_full", {31'd0, up1.ready}, 32'd0);
    repeat (3) tick();
    check_eq("bp_hold_a", {16'd0, dn1.data}, 32'hAAAA);
    check_eq("bp_stall4", {16'd0, stall1}, 32'd4);
    dn1.ready = 1'b1;
    tick();
    check_eq("bp_head_b", {16'd0, dn1.data}, 32'hBBBB);
    check_eq("bp_occ1", {30'd0, occ1}, 32'd1);
    check_eq("bp_ready_back", {31'd0, up1.ready}, 32'd1);
    tick();
    check_eq("bp_empty", {30'd0, occ1}, 32'd0);
    check_eq("bp_stall_keep", {16'd0, stall1}, 32'd4);

    // Kill clears only the masked control bits
    up1.valid = 1'b1; up1.data = 16'h1234; up1.ctrl = 16'hFFFF; up1.kill = 1'b1;
    tick();
    check_eq("kill_ctrl", {16'd0, dn1.ctrl}, 32'hFF0F);
    check_eq("kill_data", {16'd0, dn1.data}, 32'h1234);
    up1.data = 16'h4321; up1.ctrl = 16'h00F0; up1.kill = 1'b0;
    tick();
    check_eq("nokill_ctrl", {16'd0, dn1.ctrl}, 32'h00F0);
    check_eq("nokill_data", {16'd0, dn1.data}, 32'h4321);
    check_eq("acc_drain_occ", {30'd0, occ1}, 32'd1);
    up1.valid = 1'b0;
    tick();

    // Flush with two held beats and an offered beat
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 16'h1111; up1.ctrl = 16'h0000;
    tick();
    up1.data = 16'h2222;
    tick();
    check_eq("fl_occ2", {30'd0, occ1}, 32'd2);
    up1.data = 16'h5555;
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    up1.valid = 1'b0;
    check_eq("fl_valid", {31'd0, dn1.valid}, 32'd0);
    check_eq("fl_occ0", {30'd0, occ1}, 32'd0);
    check_eq("fl_ready", {31'd0, up1.ready}, 32'd1);
    check_eq("fl_stall_kept", {16'd0, stall1}, 32'd6);
    // Flush together with an accepted beat from occupancy 1
    up1.valid = 1'b1; up1.data = 16'h7777;
    tick();
    up1.data = 16'h6666;
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    up1.valid = 1'b0;
    dn1.ready = 1'b1;
    check_eq("fl_acc_occ0", {30'd0, occ1}, 32'd0);
    tick();
    check_eq("fl_no_ghost", {31'd0, dn1.valid}, 32'd0);

    // Non-skid: combinational in_ready follows out_ready
    dn0.ready = 1'b0;
    up0.valid = 1'b1; up0.data = 16'h0A0A; up0.ctrl = 16'h00FF;
    tick();
    check_eq("ns_ready_full", {31'd0, up0.ready}, 32'd0);
    check_eq("ns_occ1", {30'd0, occ0}, 32'd1);
    check_eq("ns_head", {16'd0, dn0.data}, 32'h0A0A);
    up0.data = 16'h0B0B; up0.ctrl = 16'hFFFF; up0.kill = 1'b1;
    dn0.ready = 1'b1;
    #1;
    check_eq("ns_ready_comb", {31'd0, up0.ready}, 32'd1);
    tick();
    up0.valid = 1'b0; up0.kill = 1'b0;
    check_eq("ns_next", {16'd0, dn0.data}, 32'h0B0B);
    check_eq("ns_kill_all", {16'd0, dn0.ctrl}, 32'h0000);
    tick();
    check_eq("ns_drained", {31'd0, dn0.valid}, 32'd0);

    // Counter saturation, then asynchronous reset between edges
    dn4.ready = 1'b0;
    up4.valid = 1'b1; up4.data = 16'h00C1;
    tick();
    up4.data = 16'h00C2;
    tick();
    up4.valid = 1'b0;
    repeat (20) tick();
    check_eq("sat_occ2", {30'd0, occ4}, 32'd2);
    check_eq("sat_stall", {28'd0, stall4}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", {31'd0, dn4.valid}, 32'd0);
    check_eq("ar_occ", {30'd0, occ4}, 32'd0);
    check_eq("ar_stall", {28'd0, stall4}, 32'd0);
    check_eq("ar_ready", {31'd0, up4.ready}, 32'd1);
    #10;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
